// File: rtl/u_rx_pkg.sv
// Shared definitions for the UART receive-side controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package u_rx_pkg;

    // Qualifier states: idle-high, counting a low run, waiting for the rising edge
    typedef enum logic [1:0] {
        S_HIGH = 2'b00,
        S_LOW  = 2'b01,
        S_QUAL = 2'b10
    } qual_state_e;

    localparam int DEF_DEPTH      = 4;
    localparam int DEF_MIN_LOW    = 16;
    localparam int DEF_GAP_CYCLES = 160;

endpackage

// File: rtl/u_rx_fifo.sv
// Circular-buffer FIFO holding qualified receive bytes.
// Latency: push visible on rdata_o/count_o the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop frees the slot the same cycle.
module u_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DW-1:0]          wdata_i,
    output logic [DW-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A pop on an empty FIFO is dropped; a pop on a full FIFO makes room for a push
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage: only the slot under the write pointer changes
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/u_rec_ctrl.sv
// Qualifies receiver byte completions, queues them, flags overrun and end-of-burst gaps.
// Latency: readyH first sampled high at edge t -> byte visible on rx_dataH after edge t+2.
// Backpressure: full FIFO without a same-cycle take drops the byte and sets rx_overrunH.
module u_rec_ctrl
    import u_rx_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MIN_LOW    = DEF_MIN_LOW,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic [7:0]             rec_dataH,
    input  logic                   rec_readyH,
    input  logic                   rx_enH,
    output logic [7:0]             rx_dataH,
    output logic                   rx_validH,
    input  logic                   rx_takeH,
    output logic [$clog2(DEPTH):0] rx_countH,
    output logic                   rx_overrunH,
    input  logic                   clr_errH,
    output logic                   rx_gapH
);
    localparam int            LW      = $clog2(MIN_LOW) + 1;
    localparam logic [LW-1:0] LOW_TGT = LW'(MIN_LOW - 1);
    localparam logic [LW-1:0] LOW_MAX = '1;
    localparam logic [15:0]   GAP_TGT = 16'(GAP_CYCLES - 1);

    logic          rdy_s_q;
    logic          rdy_d_q;
    qual_state_e   state_q, state_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic          evt_q, evt_d;
    logic [7:0]    evt_dat_q, evt_dat_d;
    logic          ovr_q;
    logic [15:0]   gap_cnt_q, gap_cnt_d;
    logic          gap_arm_q, gap_arm_d;
    logic          gap_q, gap_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;
    logic          ovr_set;

    // Two-flop sampler on the receiver ready level; idles high so reset looks like "not receiving"
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rdy_s_q <= 1'b1;
            rdy_d_q <= 1'b1;
        end else begin
            rdy_s_q <= rec_readyH;
            rdy_d_q <= rdy_s_q;
        end
    end

    // Qualifier and event registers
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q   <= S_HIGH;
            low_cnt_q <= '0;
            evt_q     <= 1'b0;
            evt_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            low_cnt_q <= low_cnt_d;
            evt_q     <= evt_d;
            evt_dat_q <= evt_dat_d;
        end
    end

    // Qualifier next state: a low run must last MIN_LOW samples before its rising edge counts
    always_comb begin
        state_d   = state_q;
        low_cnt_d = low_cnt_q;
        evt_d     = 1'b0;
        evt_dat_d = evt_dat_q;
        case (state_q)
            S_HIGH: begin
                if (!rdy_s_q) begin
                    low_cnt_d = '0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (rdy_s_q) begin
                    state_d = S_HIGH;   // false start, no byte
                end else begin
                    if (low_cnt_q != LOW_MAX) begin
                        low_cnt_d = low_cnt_q + LW'(1);
                    end
                    if (low_cnt_d >= LOW_TGT) begin
                        state_d = S_QUAL;
                    end
                end
            end
            S_QUAL: begin
                if (rdy_s_q && !rdy_d_q) begin
                    evt_d     = 1'b1;
                    evt_dat_d = rec_dataH;
                    state_d   = S_HIGH;
                end
            end
            default: state_d = S_HIGH;
        endcase
    end

    // Push/overrun decision; a same-cycle take frees the slot on a full FIFO
    assign pop     = rx_takeH & ~fifo_empty;
    assign push_ok = evt_q & rx_enH & (~fifo_full | pop);
    assign ovr_set = evt_q & rx_enH & fifo_full & ~pop;

    u_rx_fifo #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .push_i    (push_ok),
        .pop_i     (pop),
        .wdata_i   (evt_dat_q),
        .rdata_o   (rx_dataH),
        .count_o   (rx_countH),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Sticky overrun; a new overrun beats a simultaneous clear
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (clr_errH) begin
            ovr_q <= 1'b0;
        end
    end

    // Gap timer next state: each accepted push restarts the idle count and re-arms
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        gap_arm_d = gap_arm_q;
        gap_d     = 1'b0;
        if (gap_arm_q) begin
            gap_cnt_d = gap_cnt_q + 16'd1;
            if (gap_cnt_q == GAP_TGT) begin
                gap_d     = 1'b1;
                gap_arm_d = 1'b0;
            end
        end
        if (push_ok) begin
            gap_cnt_d = '0;
            gap_arm_d = 1'b1;
        end
    end

    // Gap timer registers; pulse is registered so it lands GAP_CYCLES edges after the push
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            gap_cnt_q <= '0;
            gap_arm_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            gap_arm_q <= gap_arm_d;
            gap_q     <= gap_d;
        end
    end

    assign rx_validH   = ~fifo_empty;
    assign rx_overrunH = ovr_q;
    assign rx_gapH     = gap_q;

endmodule
